lane_stripe_ctrl: RTL and testbench
===================================

// Module: lane_stripe_ctrl
// PURPOSE
//  Parametrised byte-to-lane striping engine feeding per-lane scrambler/8b10b/serializer chains.
//  - Stripes a Data-block byte stream across a runtime-selected link width (x1..xNUM_LANES).
//  - Broadcasts Ordered Set (OS) bytes to all active lanes.
//  - Pads partial stripes with PAD (K23.7) before an OS.
//  - Uses valid/ready handshakes on both sides.
// PARAMETERS
//  NUM_LANES     16    max lanes; power of 2, 1..16
//  DATA_WIDTH    8     bits per lane symbol
//  SKP_INTERVAL  1180  stripe times between SKP OS insertions (SKP_INSERT_EN only)
// PORTS
//  clk_i              in   1                     clock
//  rst_i              in   1                     synchronous reset, active-high
//  link_width_i       in   3                     log2 active lanes (0=x1 .. 4=x16)
//  data_i             in   DATA_WIDTH            input byte
//  data_k_i           in   1                     byte is a K symbol
//  data_os_i          in   1                     byte belongs to an Ordered Set
//  data_valid_i       in   1                     input byte valid
//  data_ready_o       out  1                     byte accepted when valid&ready
//  lane_data_o        out  NUM_LANES*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//  lane_k_o           out  NUM_LANES             per-lane K flag
//  lane_active_o      out  NUM_LANES             active-lane mask, bits [W-1:0] set
//  lane_os_o          out  1                     stripe is OS (scrambler bypass)
//  lane_valid_o       out  1                     stripe valid, all lanes aligned
//  lane_ready_i       in   1                     downstream accepts stripe
// BEHAVIOUR
//  Reset values:
//  - All outputs 0 except lane_active_o = 1 and data_ready_o = 0.
//  - idx = 0; W register = 1, then loaded from link_width_i on the first cycle after reset.
//  Width:
//  - W = 1<<link_width_i. Values above log2(NUM_LANES) clamp to NUM_LANES.
//  - W updates only when idx==0 and no PAD or OS is pending, so a stripe never changes width mid-way.
//  Output register:
//  - out_free = !lane_valid_o | lane_ready_i.
//  - lane_valid_o holds, with stable data, until lane_ready_i.
//  Data byte (data_os_i=0):
//  - Written to assembly lane idx with its K flag; idx increments.
//  - When idx==W-1, the stripe moves to the output register in the same cycle and idx wraps to 0.
//  - Latency: last byte accepted at cycle N -> lane_valid_o=1 at N+1.
//  - data_ready_o = (idx!=W-1) | out_free, gated low while PAD is pending.
//  OS byte (data_os_i=1):
//  - Accepted only when idx==0 & out_free.
//  - Broadcast to lanes 0..W-1 as one stripe with lane_os_o=1. Latency 1.
//  OS at a non-zero idx:
//  - data_ready_o=0 and the FSM enters PAD.
//  - Lanes idx..W-1 are filled with 8'hF7, k=1.
//  - The stripe issues when out_free; then idx=0 and the FSM returns to FILL.
//  FSM: FILL -> PAD (OS pending & idx!=0) -> FILL.
//  - With SKP_INSERT_EN: FILL -> SKP -> FILL (see CONFIGURATION).
//  Inactive lanes (>=W): data 0, k 0 in every stripe.
//  Simultaneous events:
//  - Stripe completion with lane_ready_i=1 and lane_valid_o=1: old stripe retires, new stripe loads the same cycle; no bubble.
//  Reset mid-stripe: partial assembly is discarded, nothing is emitted, idx=0.
//  Upstream presents each OS's bytes back-to-back (COM first).
// CONFIGURATION
//  Macro SKP_INSERT_EN.
//  Defined:
//  - A 16-bit counter increments per issued non-SKP stripe and saturates at SKP_INTERVAL.
//  - At saturation, when idx==0 and the input is not mid-OS, the FSM enters SKP.
//  - SKP: data_ready_o=0; issues 4 OS stripes BC(K28.5), 1C, 1C, 1C, all k=1, lane_os_o=1, each on out_free.
//  - Counter clears on SKP entry.
//  - Mid-OS means the last accepted byte had data_os_i=1 and the next valid byte also has data_os_i=1 without a COM.
//  Undefined: no counter, no SKP state, and SKP_INTERVAL is ignored.
// TESTING
//  1. x4, bytes 01..08 valid, ready_i=1 -> stripes {04,03,02,01},{08,07,06,05} at cycles 5,9; lanes 4..15 = 0.
//  2. x4, data 11,22, then OS byte BC k=1 -> PAD stripe {F7,F7,22,11} k=1100, then OS stripe {BC,BC,BC,BC} lane_os_o=1.
//  3. x1, lane_ready_i held 0 for 5 cycles after first stripe -> data_ready_o=0, lane_data_o stable 5 cycles, no byte lost.
//  4. x8 -> link_width_i changed to 1 after 3 bytes -> W stays 8 until wrap, next stripe uses x2.
//  5. Reset asserted after 2 of 4 bytes at x4 -> lane_valid_o=0, next 4 bytes form a clean stripe at lane 0.
//  6. SKP_INSERT_EN, SKP_INTERVAL=3, x2 streaming -> after 3 data stripes: BC,1C,1C,1C stripes, data_ready_o=0 4 cycles.

Source files
------------

// File: rtl/lane_stripe_ctrl.sv
// lane_stripe_ctrl: stripes a byte stream across 1..NUM_LANES lanes.
// Ordered Set bytes are broadcast to all active lanes, and a partial stripe
// is closed with PAD (K23.7) before an OS is sent.
// Optional feature macro: SKP_INSERT_EN (periodic SKP ordered-set insertion).

// One lane of the assembly buffer plus its output-stripe mux.
module lane_stripe_slot #(
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          wr,
  input  logic [DW-1:0] din,
  input  logic          kin,
  input  logic          act,
  input  logic          bcast,
  input  logic [DW-1:0] bc_d,
  input  logic          bc_k,
  input  logic          pad,
  output logic [DW-1:0] out_d,
  output logic          out_k
);
  logic [DW-1:0] asm_d;
  logic          asm_k;

  // Assembly holding register; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (wr) begin
      asm_d <= din;
      asm_k <= kin;
    end
  end

  // Lane content of a stripe that would load this cycle.
  always_comb begin
    out_d = asm_d;
    out_k = asm_k;
    if (!act) begin
      out_d = '0;
      out_k = 1'b0;
    end else if (bcast) begin
      out_d = bc_d;
      out_k = bc_k;
    end else if (wr) begin
      out_d = din;
      out_k = kin;
    end else if (pad) begin
      out_d = DW'(8'hF7);
      out_k = 1'b1;
    end
  end
endmodule

module lane_stripe_ctrl #(
  parameter int NUM_LANES    = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int SKP_INTERVAL = 1180
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [2:0]                      link_width_i,
  input  logic [DATA_WIDTH-1:0]           data_i,
  input  logic                            data_k_i,
  input  logic                            data_os_i,
  input  logic                            data_valid_i,
  output logic                            data_ready_o,
  output logic [NUM_LANES*DATA_WIDTH-1:0] lane_data_o,
  output logic [NUM_LANES-1:0]            lane_k_o,
  output logic [NUM_LANES-1:0]            lane_active_o,
  output logic                            lane_os_o,
  output logic                            lane_valid_o,
  input  logic                            lane_ready_i
);
  localparam int          IW    = 5;
  localparam logic [2:0]  LOG_L = 3'($clog2(NUM_LANES));

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_PAD  = 2'd1
`ifdef SKP_INSERT_EN
    , S_SKP = 2'd2
`endif
  } st_t;

  st_t                                 st, nxt;
  logic [IW-1:0]                       idx, idx_nxt, w_m1;
  logic [2:0]                          w_log, w_eff, lw_clamp;
  logic                                out_free, last, load, bcast, os_out, pad_sel, acc_data;
  logic [DATA_WIDTH-1:0]               bc_d;
  logic                                bc_k;
  logic [NUM_LANES-1:0]                wr_vec, act_vec, pad_vec;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] stripe_d;
  logic [NUM_LANES-1:0]                stripe_k;
  logic                                skp_go;

  assign out_free = !lane_valid_o | lane_ready_i;
  assign lw_clamp = (link_width_i > LOG_L) ? LOG_L : link_width_i;
  // Width may only follow link_width_i at a stripe boundary; otherwise it is locked.
  assign w_eff    = (st == S_FILL && idx == '0) ? lw_clamp : w_log;
  assign w_m1     = IW'((6'd1 << w_eff) - 6'd1);
  assign last     = (idx == w_m1);

`ifdef SKP_INSERT_EN
  logic [15:0] skp_cnt;
  logic [1:0]  skp_n;
  logic        last_os, mid_os, skp_issue;
  assign mid_os = last_os & data_valid_i & data_os_i &
                  !(data_k_i && data_i == DATA_WIDTH'(8'hBC));
  assign skp_go = (st == S_FILL) && (skp_cnt == 16'(SKP_INTERVAL)) &&
                  (idx == '0) && !mid_os;
`else
  logic unused_skp;
  assign unused_skp = ^16'(SKP_INTERVAL);
  assign skp_go     = 1'b0;
`endif

  // Per-lane control vectors.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      act_vec[i] = (IW'(i) <= w_m1);
      pad_vec[i] = pad_sel && (IW'(i) >= idx);
      wr_vec[i]  = acc_data && (IW'(i) == idx);
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_stripe_slot #(.DW(DATA_WIDTH)) u_slot (
      .clk_i (clk_i),
      .wr    (wr_vec[g]),
      .din   (data_i),
      .kin   (data_k_i),
      .act   (act_vec[g]),
      .bcast (bcast),
      .bc_d  (bc_d),
      .bc_k  (bc_k),
      .pad   (pad_vec[g]),
      .out_d (stripe_d[g]),
      .out_k (stripe_k[g])
    );
  end

  // Next-state, handshake and stripe-load decode.
  always_comb begin
    nxt          = st;
    idx_nxt      = idx;
    data_ready_o = 1'b0;
    load         = 1'b0;
    bcast        = 1'b0;
    bc_d         = '0;
    bc_k         = 1'b0;
    os_out       = 1'b0;
    pad_sel      = 1'b0;
    acc_data     = 1'b0;
`ifdef SKP_INSERT_EN
    skp_issue    = 1'b0;
`endif
    case (st)
      S_FILL: begin
        if (skp_go) begin
`ifdef SKP_INSERT_EN
          if (out_free) begin
            load      = 1'b1;
            bcast     = 1'b1;
            bc_d      = DATA_WIDTH'(8'hBC);
            bc_k      = 1'b1;
            os_out    = 1'b1;
            skp_issue = 1'b1;
            nxt       = S_SKP;
          end
`endif
        end else if (data_os_i) begin
          if (idx == '0) begin
            data_ready_o = out_free;
            if (data_valid_i && out_free) begin
              load   = 1'b1;
              bcast  = 1'b1;
              bc_d   = data_i;
              bc_k   = data_k_i;
              os_out = 1'b1;
            end
          end else if (data_valid_i) begin
            nxt = S_PAD;
          end
        end else begin
          data_ready_o = !last | out_free;
          if (data_valid_i && data_ready_o) begin
            acc_data = 1'b1;
            if (last) begin
              load    = 1'b1;
              idx_nxt = '0;
            end else begin
              idx_nxt = idx + IW'(1);
            end
          end
        end
      end
      S_PAD: begin
        pad_sel = 1'b1;
        if (out_free) begin
          load    = 1'b1;
          idx_nxt = '0;
          nxt     = S_FILL;
        end
      end
`ifdef SKP_INSERT_EN
      S_SKP: begin
        if (out_free) begin
          load      = 1'b1;
          bcast     = 1'b1;
          bc_d      = DATA_WIDTH'(8'h1C);
          bc_k      = 1'b1;
          os_out    = 1'b1;
          skp_issue = 1'b1;
          if (skp_n == 2'd3) nxt = S_FILL;
        end
      end
`endif
      default: nxt = S_FILL;
    endcase
    if (rst_i) data_ready_o = 1'b0;
  end

  // State, index, width and output stripe register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st            <= S_FILL;
      idx           <= '0;
      w_log         <= '0;
      lane_valid_o  <= 1'b0;
      lane_data_o   <= '0;
      lane_k_o      <= '0;
      lane_os_o     <= 1'b0;
      lane_active_o <= NUM_LANES'(1);
    end else begin
      st    <= nxt;
      idx   <= idx_nxt;
      w_log <= w_eff;
      if (load) begin
        lane_valid_o  <= 1'b1;
        lane_data_o   <= stripe_d;
        lane_k_o      <= stripe_k;
        lane_os_o     <= os_out;
        lane_active_o <= act_vec;
      end else if (lane_ready_i) begin
        lane_valid_o  <= 1'b0;
      end
    end
  end

`ifdef SKP_INSERT_EN
  // SKP interval counter, burst position and OS-continuation tracking.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      skp_cnt <= '0;
      skp_n   <= '0;
      last_os <= 1'b0;
    end else begin
      if (data_valid_i && data_ready_o) last_os <= data_os_i;
      if (skp_issue) begin
        skp_n <= (st == S_FILL) ? 2'd1 : skp_n + 2'd1;
        if (st == S_FILL) skp_cnt <= '0;
      end else if (load && skp_cnt != 16'(SKP_INTERVAL)) begin
        skp_cnt <= skp_cnt + 16'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_lane_stripe_ctrl.sv
// Directed bench for lane_stripe_ctrl (16 lanes x 8 bits).
module tb_lane_stripe_ctrl;
  localparam int NL = 16;
  localparam int DW = 8;
`ifdef SKP_INSERT_EN
  localparam int SKPI = 3;
`else
  localparam int SKPI = 1180;
`endif

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [2:0]        link_width_i;
  logic [DW-1:0]     data_i;
  logic              data_k_i, data_os_i, data_valid_i, data_ready_o;
  logic [NL*DW-1:0]  lane_data_o;
  logic [NL-1:0]     lane_k_o, lane_active_o;
  logic              lane_os_o, lane_valid_o, lane_ready_i;

  int n_err = 0;
  int n_chk = 0;

  lane_stripe_ctrl #(.NUM_LANES(NL), .DATA_WIDTH(DW), .SKP_INTERVAL(SKPI)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .link_width_i (link_width_i),
    .data_i       (data_i),
    .data_k_i     (data_k_i),
    .data_os_i    (data_os_i),
    .data_valid_i (data_valid_i),
    .data_ready_o (data_ready_o),
    .lane_data_o  (lane_data_o),
    .lane_k_o     (lane_k_o),
    .lane_active_o(lane_active_o),
    .lane_os_o    (lane_os_o),
    .lane_valid_o (lane_valid_o),
    .lane_ready_i (lane_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic drv(input logic [7:0] d, input logic k, input logic os, input logic v);
    data_i = d; data_k_i = k; data_os_i = os; data_valid_i = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; link_width_i = 3'd2; lane_ready_i = 1'b1;
    drv(8'h00, 1'b0, 1'b0, 1'b0);
    step(); step();
    #1;
    chk("rst_valid",  128'(lane_valid_o),  128'd0);
    chk("rst_ready",  128'(data_ready_o),  128'd0);
    chk("rst_active", 128'(lane_active_o), 128'd1);
    chk("rst_data",   lane_data_o,         128'd0);
    chk("rst_os",     128'(lane_os_o),     128'd0);
    rst_i = 1'b0;
    step();

`ifdef SKP_INSERT_EN
    // x2 streaming: three data stripes, then a BC,1C,1C,1C SKP burst
    link_width_i = 3'd1;
    for (int b = 1; b <= 6; b++) begin
      drv(8'(b), 1'b0, 1'b0, 1'b1);
      step();
    end
    drv(8'h07, 1'b0, 1'b0, 1'b1);
    #1 chk("skp_rdy0", 128'(data_ready_o), 128'd0);
    step();
    chk("skp_bc",    lane_data_o,         128'hBCBC);
    chk("skp_bc_k",  128'(lane_k_o),      128'h3);
    chk("skp_bc_os", 128'(lane_os_o),     128'd1);
    chk("skp_rdy1",  128'(data_ready_o),  128'd0);
    for (int j = 0; j < 3; j++) begin
      step();
      chk("skp_1c",    lane_data_o,        128'h1C1C);
      chk("skp_1c_os", 128'(lane_os_o),    128'd1);
      chk("skp_rdy",   128'(data_ready_o), (j == 2) ? 128'd1 : 128'd0);
    end
    step();
    drv(8'h08, 1'b0, 1'b0, 1'b1);
    step();
    chk("skp_after",    lane_data_o,     128'h0807);
    chk("skp_after_os", 128'(lane_os_o), 128'd0);
    drv(8'h00, 1'b0, 1'b0, 1'b0);
    step();
`else
    // 1: x4 streaming, bytes 01..08
    for (int b = 1; b <= 8; b++) begin
      drv(8'(b), 1'b0, 1'b0, 1'b1);
      step();
      if (b == 3) chk("t1_nv3", 128'(lane_valid_o), 128'd0);
      if (b == 4) begin
        chk("t1_v4",   128'(lane_valid_o),  128'd1);
        chk("t1_d0",   lane_data_o,         128'h04030201);
        chk("t1_k0",   128'(lane_k_o),      128'd0);
        chk("t1_act",  128'(lane_active_o), 128'hF);
        chk("t1_os",   128'(lane_os_o),     128'd0);
      end
      if (b == 5) chk("t1_drop", 128'(lane_valid_o), 128'd0);
      if (b == 8) begin
        chk("t1_v8", 128'(lane_valid_o), 128'd1);
        chk("t1_d1", lane_data_o,        128'h08070605);
      end
    end
    drv(8'h00, 1'b0, 1'b0, 1'b0);
    step();

    // 2: x4, 11,22 then OS byte BC -> PAD stripe then OS stripe
    drv(8'h11, 1'b0, 1'b0, 1'b1); step();
    drv(8'h22, 1'b0, 1'b0, 1'b1); step();
    drv(8'hBC, 1'b1, 1'b1, 1'b1);
    #1 chk("t2_rdy_os", 128'(data_ready_o), 128'd0);
    step();
    chk("t2_pad_nv",  128'(lane_valid_o), 128'd0);
    chk("t2_pad_rdy", 128'(data_ready_o), 128'd0);
    step();
    chk("t2_pad_v",  128'(lane_valid_o), 128'd1);
    chk("t2_pad_d",  lane_data_o,        128'hF7F72211);
    chk("t2_pad_k",  128'(lane_k_o),     128'hC);
    chk("t2_pad_os", 128'(lane_os_o),    128'd0);
    step();
    chk("t2_os_d",  lane_data_o,     128'hBCBCBCBC);
    chk("t2_os_k",  128'(lane_k_o),  128'hF);
    chk("t2_os_os", 128'(lane_os_o), 128'd1);
    drv(8'h00, 1'b0, 1'b0, 1'b0);
    step();
    chk("t2_idle", 128'(lane_valid_o), 128'd0);

    // 3: x1 with downstream stall for 5 cycles
    link_width_i = 3'd0;
    drv(8'hA1, 1'b0, 1'b0, 1'b1);
    step();
    chk("t3_v",   128'(lane_valid_o),  128'd1);
    chk("t3_d",   lane_data_o,         128'hA1);
    chk("t3_act", 128'(lane_active_o), 128'h1);
    lane_ready_i = 1'b0;
    drv(8'hA2, 1'b0, 1'b0, 1'b1);
    #1 chk("t3_rdy0", 128'(data_ready_o), 128'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold_d", lane_data_o,         128'hA1);
      chk("t3_hold_v", 128'(lane_valid_o),  128'd1);
      chk("t3_hold_r", 128'(data_ready_o),  128'd0);
    end
    lane_ready_i = 1'b1;
    #1 chk("t3_rdy1", 128'(data_ready_o), 128'd1);
    step();
    chk("t3_next_v", 128'(lane_valid_o), 128'd1);
    chk("t3_next_d", lane_data_o,        128'hA2);
    drv(8'h00, 1'b0, 1'b0, 1'b0);
    step();
    chk("t3_idle", 128'(lane_valid_o), 128'd0);

    // 4: x8, width request changes to x2 mid-stripe
    link_width_i = 3'd3;
    for (int b = 1; b <= 10; b++) begin
      if (b == 4) link_width_i = 3'd1;
      drv(8'(b), 1'b0, 1'b0, 1'b1);
      step();
      if (b == 8) begin
        chk("t4_d8",   lane_data_o,         128'h0807060504030201);
        chk("t4_act8", 128'(lane_active_o), 128'hFF);
      end
      if (b == 10) begin
        chk("t4_d2",   lane_data_o,         128'h0A09);
        chk("t4_act2", 128'(lane_active_o), 128'h3);
      end
    end
    drv(8'h00, 1'b0, 1'b0, 1'b0);
    step();

    // width code above max clamps to x16
    link_width_i = 3'd7;
    for (int b = 0; b < 16; b++) begin
      drv(8'(8'h50 + b), 1'b0, 1'b0, 1'b1);
      step();
    end
    chk("cl_d",   lane_data_o,         128'h5F5E5D5C5B5A59585756555453525150);
    chk("cl_act", 128'(lane_active_o), 128'hFFFF);
    drv(8'h00, 1'b0, 1'b0, 1'b0);
    step();

    // 5: reset after 2 of 4 bytes at x4
    link_width_i = 3'd2;
    drv(8'h31, 1'b0, 1'b0, 1'b1); step();
    drv(8'h32, 1'b0, 1'b0, 1'b1); step();
    drv(8'h00, 1'b0, 1'b0, 1'b0);
    rst_i = 1'b1;
    step();
    #1;
    chk("t5_rst_v",   128'(lane_valid_o),  128'd0);
    chk("t5_rst_r",   128'(data_ready_o),  128'd0);
    chk("t5_rst_act", 128'(lane_active_o), 128'd1);
    rst_i = 1'b0;
    step();
    chk("t5_post_v", 128'(lane_valid_o), 128'd0);
    for (int b = 1; b <= 4; b++) begin
      drv(8'(8'h40 + b), 1'b0, 1'b0, 1'b1);
      step();
      if (b == 3) chk("t5_nv3", 128'(lane_valid_o), 128'd0);
    end
    chk("t5_v",   128'(lane_valid_o),  128'd1);
    chk("t5_d",   lane_data_o,         128'h44434241);
    chk("t5_act", 128'(lane_active_o), 128'hF);
    drv(8'h00, 1'b0, 1'b0, 1'b0);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
